// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one AND/OR logic unit between two requesters.
// Define LOGIC_UNIT_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module logic_unit_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       gnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             pick1;

`ifdef LOGIC_UNIT_ARB_FIXED_PRIO_EN
    always_comb begin
        pick1 = req1 & ~req0;
    end
`else
    // last_grant is the index of the most recently served requester
    logic last_grant;

    always_comb begin
        pick1 = req1 & (~req0 | ~last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            last_grant <= pick1;
        end
    end
`endif

    // Operands are captured once at grant; the ack is issued on leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            gnt    <= 2'b00;
            busy   <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt   <= pick1 ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        op_q  <= pick1 ? op1 : op0;
                        a_q   <= pick1 ? a1 : a0;
                        b_q   <= pick1 ? b1 : b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result <= op_q ? (a_q & b_q) : (a_q | b_q);
                    state  <= DONE;
                end
                DONE: begin
                    ack0  <= gnt[0];
                    ack1  <= gnt[1];
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed vector table, corner sequences
// and randomized traffic against a transaction-level model.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic             op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic             op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] result;
    logic [1:0]       gnt;
    logic             busy;

    int pass_count = 0;
    int check_count = 0;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .b1     (b1),
        .ack0   (ack0),
        .ack1   (ack1),
        .result (result),
        .gnt    (gnt),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {ack0, ack1, gnt, busy, result}
    typedef struct {
        logic       req0;
        logic       op0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       req1;
        logic       op1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [8:0] exp;
    } vec_t;

    vec_t vectors[$];

    function automatic logic [8:0] pack_exp(input logic e_ack0, input logic e_ack1,
                                            input logic [1:0] e_gnt, input logic e_busy,
                                            input logic [3:0] e_res);
        return {e_ack0, e_ack1, e_gnt, e_busy, e_res};
    endfunction

    task automatic add_row(input logic r0, input logic o0, input logic [3:0] x0, input logic [3:0] y0,
                           input logic r1, input logic o1, input logic [3:0] x1, input logic [3:0] y1,
                           input logic [8:0] e);
        vec_t v;
        v.req0 = r0; v.op0 = o0; v.a0 = x0; v.b0 = y0;
        v.req1 = r1; v.op1 = o1; v.a1 = x1; v.b1 = y1;
        v.exp  = e;
        vectors.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        req0 = v.req0; op0 = v.op0; a0 = v.a0; b0 = v.b0;
        req1 = v.req1; op1 = v.op1; a1 = v.a1; b1 = v.b1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] e);
        logic [8:0] got;
        got = {ack0, ack1, gnt, busy, result};
        check_count++;
        if (got === e) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got ack0=%b ack1=%b gnt=%b busy=%b result=%b, expected ack0=%b ack1=%b gnt=%b busy=%b result=%b",
                     name, got[8], got[7], got[6:5], got[4], got[3:0],
                     e[8], e[7], e[6:5], e[4], e[3:0]);
        end
    endtask

    // Transaction-level reference: a grant occupies three slots (gnt, gnt+result, ack)
    int         m_grant_edge;
    int         m_owner;
    int         m_last;
    logic [3:0] m_old_res;
    logic [3:0] m_new_res;

    task automatic model_edge(input int k);
        int winner;
        if (k - m_grant_edge >= 3 && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef LOGIC_UNIT_ARB_FIXED_PRIO_EN
                winner = 0;
`else
                winner = (m_last == 1) ? 0 : 1;
`endif
            end else begin
                winner = req1 ? 1 : 0;
            end
            m_old_res = m_new_res;
            if (winner == 1) m_new_res = op1 ? (a1 & b1) : (a1 | b1);
            else             m_new_res = op0 ? (a0 & b0) : (a0 | b0);
            m_grant_edge = k;
            m_owner = winner;
            m_last = winner;
        end
    endtask

    function automatic logic [8:0] model_expect(input int k);
        int         d;
        logic [1:0] onehot;
        d = k - m_grant_edge;
        onehot = (m_owner == 1) ? 2'b10 : 2'b01;
        return pack_exp(d == 2 && m_owner == 0, d == 2 && m_owner == 1,
                        (d <= 1) ? onehot : 2'b00, d <= 1,
                        (d >= 1) ? m_new_res : m_old_res);
    endfunction

    initial begin
        logic [3:0] prev;
        logic [3:0] res;
        int         owner;
        logic [1:0] oh;

        rst_n = 1'b0;
        req0 = 1'b1; op0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b1; op1 = 1'b0; a1 = '0; b1 = '0;
        step();
        step();
        checkOutput("reset_hold", pack_exp(0, 0, 2'b00, 0, 4'b0000));
        req0 = 1'b0;
        req1 = 1'b0;
        rst_n = 1'b1;

        // Single AND, then single OR with a1 changed during EXEC
        add_row(1, 1, 4'b1100, 4'b1010, 0, 0, 4'h0, 4'h0, pack_exp(0, 0, 2'b01, 1, 4'b0000));
        add_row(1, 1, 4'b1100, 4'b1010, 0, 0, 4'h0, 4'h0, pack_exp(0, 0, 2'b01, 1, 4'b1000));
        add_row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, pack_exp(1, 0, 2'b00, 0, 4'b1000));
        add_row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, pack_exp(0, 0, 2'b00, 0, 4'b1000));
        add_row(0, 0, 4'h0, 4'h0, 1, 0, 4'b1100, 4'b0011, pack_exp(0, 0, 2'b10, 1, 4'b1000));
        add_row(0, 0, 4'h0, 4'h0, 1, 0, 4'b0000, 4'b0011, pack_exp(0, 0, 2'b10, 1, 4'b1111));
        add_row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, pack_exp(0, 1, 2'b00, 0, 4'b1111));
        add_row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, pack_exp(0, 0, 2'b00, 0, 4'b1111));

        // Contention: both held for four operations
        prev = 4'b1111;
        for (int k = 0; k < 4; k++) begin
`ifdef LOGIC_UNIT_ARB_FIXED_PRIO_EN
            owner = 0;
`else
            owner = k % 2;
`endif
            res = (owner == 1) ? 4'b0000 : 4'b1111;
            oh  = (owner == 1) ? 2'b10 : 2'b01;
            add_row(1, 1, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, pack_exp(0, 0, oh, 1, prev));
            add_row(1, 1, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0, pack_exp(0, 0, oh, 1, res));
            add_row(k != 3, 1, 4'hF, 4'hF, k != 3, 0, 4'h0, 4'h0,
                    pack_exp(owner == 0, owner == 1, 2'b00, 0, res));
            prev = res;
        end
        add_row(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, pack_exp(0, 0, 2'b00, 0, prev));

        foreach (vectors[i]) begin
            applyStimulus(vectors[i]);
            step();
            checkOutput($sformatf("vector_%0d", i), vectors[i].exp);
        end

        // Abandoned wait: requester 1 drops out while requester 0 is served
        req0 = 1'b1; op0 = 1'b0; a0 = 4'b0101; b0 = 4'b0010;
        req1 = 1'b1; op1 = 1'b1; a1 = 4'b1111; b1 = 4'b1111;
        step();
        checkOutput("abandon_grant", pack_exp(0, 0, 2'b01, 1, prev));
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        checkOutput("abandon_exec", pack_exp(0, 0, 2'b01, 1, 4'b0111));
        step();
        checkOutput("abandon_ack0", pack_exp(1, 0, 2'b00, 0, 4'b0111));
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("abandon_idle", pack_exp(0, 0, 2'b00, 0, 4'b0111));
        end

        // Reset pulsed during EXEC, then a clean operation
        req0 = 1'b1; op0 = 1'b1; a0 = 4'b1111; b0 = 4'b0110;
        step();
        checkOutput("midrst_grant", pack_exp(0, 0, 2'b01, 1, 4'b0111));
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_abort", pack_exp(0, 0, 2'b00, 0, 4'b0000));
        #2;
        rst_n = 1'b1;
        step();
        checkOutput("midrst_regrant", pack_exp(0, 0, 2'b01, 1, 4'b0000));
        req0 = 1'b0;
        step();
        checkOutput("midrst_exec", pack_exp(0, 0, 2'b01, 1, 4'b0110));
        step();
        checkOutput("midrst_ack", pack_exp(1, 0, 2'b00, 0, 4'b0110));
        step();
        checkOutput("midrst_idle", pack_exp(0, 0, 2'b00, 0, 4'b0110));

        // Randomized traffic from a fresh reset
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        rst_n = 1'b1;
        m_grant_edge = -10;
        m_owner = 0;
        m_last = 1;
        m_old_res = 4'b0000;
        m_new_res = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            op0  = 1'($urandom_range(0, 1));
            op1  = 1'($urandom_range(0, 1));
            a0   = 4'($urandom());
            b0   = 4'($urandom());
            a1   = 4'($urandom());
            b1   = 4'($urandom());
            model_edge(k);
            step();
            checkOutput($sformatf("random_%0d", k), model_expect(k));
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
